// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the MIPS pipeline control.
//   - opcode constants (instruction[31:26])
//   - ALU-op codes driven into the EX stage
//   - packed control word produced by ctrl_decode, and its all-zero bubble
package ctrl_pkg;

  localparam int CTRL_OPW    = 6;
  localparam int CTRL_ALUOPW = 3;

  localparam logic [CTRL_OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [CTRL_OPW-1:0] OP_J     = 6'b000010;
  localparam logic [CTRL_OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [CTRL_OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [CTRL_OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [CTRL_OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [CTRL_OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [CTRL_OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [CTRL_OPW-1:0] OP_LUI   = 6'b001111;
  // jr cannot share 001000 with addi, so it gets its own opcode here.
  localparam logic [CTRL_OPW-1:0] OP_JR    = 6'b010000;
  localparam logic [CTRL_OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [CTRL_OPW-1:0] OP_SW    = 6'b101011;

  localparam logic [CTRL_ALUOPW-1:0] ALUOP_RTYPE  = 3'b000;
  localparam logic [CTRL_ALUOPW-1:0] ALUOP_BRANCH = 3'b001;
  localparam logic [CTRL_ALUOPW-1:0] ALUOP_MEM    = 3'b010;
  localparam logic [CTRL_ALUOPW-1:0] ALUOP_ADD    = 3'b011;
  localparam logic [CTRL_ALUOPW-1:0] ALUOP_AND    = 3'b100;
  localparam logic [CTRL_ALUOPW-1:0] ALUOP_OR     = 3'b101;
  localparam logic [CTRL_ALUOPW-1:0] ALUOP_SLT    = 3'b110;
  localparam logic [CTRL_ALUOPW-1:0] ALUOP_LUI    = 3'b111;

  typedef struct packed {
    logic                   regdst;
    logic                   alusrc;
    logic [CTRL_ALUOPW-1:0] aluop;
    logic                   branch;
    logic                   bne;
    logic                   memread;
    logic                   memwrite;
    logic                   regwrite;
    logic                   memtoreg;
    logic                   jump;
    logic                   jumpreg;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode -> control word decoder.
// Shared between the pipelined control and the single-cycle core.
// Ports:
//   valid   in   instruction is real; when 0 the word is a bubble
//   opcode  in   instruction[31:26]
//   ctrl    out  decoded control word (all zero for unknown opcodes)
//   uses_rt out  instruction reads rt as a source register
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic                valid,
  input  logic [CTRL_OPW-1:0] opcode,
  output ctrl_word_t          ctrl,
  output logic                uses_rt
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    uses_rt = 1'b0;
    if (valid) begin
      case (opcode)
        OP_RTYPE: begin
          ctrl.regdst   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_RTYPE;
          uses_rt       = 1'b1;
        end
        OP_BEQ: begin
          ctrl.branch = 1'b1;
          ctrl.aluop  = ALUOP_BRANCH;
          uses_rt     = 1'b1;
        end
        OP_BNE: begin
          ctrl.branch = 1'b1;
          ctrl.bne    = 1'b1;
          ctrl.aluop  = ALUOP_BRANCH;
          uses_rt     = 1'b1;
        end
        OP_LW: begin
          ctrl.alusrc   = 1'b1;
          ctrl.memread  = 1'b1;
          ctrl.memtoreg = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_MEM;
        end
        OP_SW: begin
          // sw reads rt as the store data, so it can hit a load-use hazard on rt
          ctrl.alusrc   = 1'b1;
          ctrl.memwrite = 1'b1;
          ctrl.aluop    = ALUOP_MEM;
          uses_rt       = 1'b1;
        end
        OP_ADDI: begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_ADD;
        end
        OP_ANDI: begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_AND;
        end
        OP_ORI: begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_OR;
        end
        OP_SLTI: begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_SLT;
        end
        OP_LUI: begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_LUI;
        end
        OP_J:    ctrl.jump    = 1'b1;
        OP_JR:   ctrl.jumpreg = 1'b1;
        default: ctrl         = CTRL_BUBBLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control for the 5-stage MIPS core.
// Decodes the IF/ID instruction, carries the control word through
// ID/EX, EX/MEM and MEM/WB, and produces stall/flush for load-use
// hazards, jumps and taken branches.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_valid/opcode/rs/rt      fields of the instruction in IF/ID
//   ex_branch_taken            branch condition evaluated in EX
//   pc_write, ifid_write       PC / IF/ID enables (0 during a stall)
//   ifid_flush                 zero IF/ID on the next edge
//   ex_*                       ID/EX control outputs and rt copy
//   mem_memread, mem_memwrite  EX/MEM control outputs
//   wb_regwrite, wb_memtoreg   MEM/WB control outputs
//   id_jump, id_jumpreg        combinational PC-mux redirect
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPW            = 6,
  parameter int REGW           = 5,
  parameter int ALUOPW         = 3,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OPW-1:0]    id_opcode,
  input  logic [REGW-1:0]   id_rs,
  input  logic [REGW-1:0]   id_rt,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [ALUOPW-1:0] ex_aluop,
  output logic              ex_alusrc,
  output logic              ex_regdst,
  output logic              ex_branch,
  output logic              ex_bne,
  output logic              ex_memread,
  output logic [REGW-1:0]   ex_rt,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic              id_jump,
  output logic              id_jumpreg
);

  ctrl_word_t id_ctrl;
  logic       id_uses_rt;
  logic       hazard;
  logic       branch_flush;
  logic       stall;
  logic       idex_bubble;

  // Stage-local control bits that are not ports themselves
  logic ex_memwrite, ex_regwrite, ex_memtoreg;
  logic mem_regwrite, mem_memtoreg;

  ctrl_decode u_decode (
    .valid   (id_valid),
    .opcode  (id_opcode),
    .ctrl    (id_ctrl),
    .uses_rt (id_uses_rt)
  );

  // A load in EX and a branch in EX are mutually exclusive, so branch-over-stall
  // priority only matters if the datapath ever injects both; it is kept explicit.
  always_comb begin
    branch_flush = ex_branch & ex_branch_taken;
    hazard = LOAD_USE_STALL & ex_memread & (ex_rt != '0) & id_valid &
             ((ex_rt == id_rs) | ((ex_rt == id_rt) & id_uses_rt));
    stall        = hazard & ~branch_flush;
    idex_bubble  = stall | branch_flush;
    pc_write     = ~stall;
    ifid_write   = ~stall;
    // A stalled jump is held in IF/ID and flushes when it is re-decoded.
    // Gated with rst_n so reset never requests a flush from whatever sits in IF/ID.
    ifid_flush   = rst_n & (branch_flush | (~stall & (id_ctrl.jump | id_ctrl.jumpreg)));
    id_jump      = id_ctrl.jump;
    id_jumpreg   = id_ctrl.jumpreg;
  end

  // ID/EX register: loads a bubble on stall or taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_aluop    <= '0;
      ex_alusrc   <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_bne      <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_rt       <= '0;
    end else if (idex_bubble) begin
      ex_aluop    <= '0;
      ex_alusrc   <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_bne      <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_rt       <= '0;
    end else begin
      ex_aluop    <= id_ctrl.aluop;
      ex_alusrc   <= id_ctrl.alusrc;
      ex_regdst   <= id_ctrl.regdst;
      ex_branch   <= id_ctrl.branch;
      ex_bne      <= id_ctrl.bne;
      ex_memread  <= id_ctrl.memread;
      ex_memwrite <= id_ctrl.memwrite;
      ex_regwrite <= id_ctrl.regwrite;
      ex_memtoreg <= id_ctrl.memtoreg;
      ex_rt       <= id_rt;
    end
  end

  // EX/MEM and MEM/WB always advance; a stall only freezes PC and IF/ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
    end else begin
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_regwrite <= ex_regwrite;
      mem_memtoreg <= ex_memtoreg;
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed self-checking bench for pipe_ctrl_unit.
module tb_pipe_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_branch_taken;
  logic       pc_write, ifid_write, ifid_flush;
  logic [2:0] ex_aluop;
  logic       ex_alusrc, ex_regdst, ex_branch, ex_bne, ex_memread;
  logic [4:0] ex_rt;
  logic       mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
  logic       id_jump, id_jumpreg;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .ex_aluop        (ex_aluop),
    .ex_alusrc       (ex_alusrc),
    .ex_regdst       (ex_regdst),
    .ex_branch       (ex_branch),
    .ex_bne          (ex_bne),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .mem_memread     (mem_memread),
    .mem_memwrite    (mem_memwrite),
    .wb_regwrite     (wb_regwrite),
    .wb_memtoreg     (wb_memtoreg),
    .id_jump         (id_jump),
    .id_jumpreg      (id_jumpreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {aluop, alusrc, regdst, branch, bne, memread}
  logic [7:0] ex_vec;
  assign ex_vec = {ex_aluop, ex_alusrc, ex_regdst, ex_branch, ex_bne, ex_memread};

  localparam logic [7:0] EX_RTYPE = 8'b000_01000;

  typedef struct {
    logic [5:0] op;
    logic [7:0] ex;
    logic [1:0] mem;  // {memread, memwrite}
    logic [1:0] wb;   // {regwrite, memtoreg}
    logic [1:0] jmp;  // {jump, jumpreg}
  } vec_t;

  vec_t sweep [13];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic taken);
    id_valid        = v;
    id_opcode       = op;
    id_rs           = rs;
    id_rt           = rt;
    ex_branch_taken = taken;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweep[0]  = '{6'b000000, 8'b000_01000, 2'b00, 2'b10, 2'b00};
    sweep[1]  = '{6'b000100, 8'b001_00100, 2'b00, 2'b00, 2'b00};
    sweep[2]  = '{6'b000101, 8'b001_00110, 2'b00, 2'b00, 2'b00};
    sweep[3]  = '{6'b100011, 8'b010_10001, 2'b10, 2'b11, 2'b00};
    sweep[4]  = '{6'b101011, 8'b010_10000, 2'b01, 2'b00, 2'b00};
    sweep[5]  = '{6'b001000, 8'b011_10000, 2'b00, 2'b10, 2'b00};
    sweep[6]  = '{6'b001100, 8'b100_10000, 2'b00, 2'b10, 2'b00};
    sweep[7]  = '{6'b001101, 8'b101_10000, 2'b00, 2'b10, 2'b00};
    sweep[8]  = '{6'b001010, 8'b110_10000, 2'b00, 2'b10, 2'b00};
    sweep[9]  = '{6'b001111, 8'b111_10000, 2'b00, 2'b10, 2'b00};
    sweep[10] = '{6'b000010, 8'b000_00000, 2'b00, 2'b00, 2'b10};
    sweep[11] = '{6'b010000, 8'b000_00000, 2'b00, 2'b00, 2'b01};
    sweep[12] = '{6'b111111, 8'b000_00000, 2'b00, 2'b00, 2'b00};

    // Reset held with a lw in ID
    rst_n = 1'b0;
    applyStimulus(1'b1, 6'b100011, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_ex", ex_vec, 8'h00);
    checkOutput("rst_mem_wb", {mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg}, 4'b0000);
    checkOutput("rst_enables", {pc_write, ifid_write, ifid_flush}, 3'b110);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("rst_wb_early", {wb_regwrite, wb_memtoreg}, 2'b00);
    tick();
    checkOutput("rst_wb_lat3", {wb_regwrite, wb_memtoreg}, 2'b11);

    // Decode sweep; MEM and WB trail EX by one and two entries
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, sweep[i].op, 5'd0, 5'd0, 1'b0);
      checkOutput($sformatf("jmp_%0d", i), {id_jump, id_jumpreg}, sweep[i].jmp);
      tick();
      checkOutput($sformatf("ex_%0d", i), ex_vec, sweep[i].ex);
      if (i >= 1)
        checkOutput($sformatf("mem_%0d", i), {mem_memread, mem_memwrite}, sweep[i-1].mem);
      if (i >= 2)
        checkOutput($sformatf("wb_%0d", i), {wb_regwrite, wb_memtoreg}, sweep[i-2].wb);
    end

    // id_valid=0 gives a bubble
    applyStimulus(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    tick();
    checkOutput("invalid_ex", ex_vec, 8'h00);

    // Load-use via rs: exactly one stall cycle
    applyStimulus(1'b1, 6'b100011, 5'd0, 5'd5, 1'b0);
    tick();
    checkOutput("lu_ex_rt", ex_rt, 5'd5);
    applyStimulus(1'b1, 6'b000000, 5'd5, 5'd0, 1'b0);
    checkOutput("lu_stall", {pc_write, ifid_write, ifid_flush}, 3'b000);
    tick();
    checkOutput("lu_bubble", ex_vec, 8'h00);
    checkOutput("lu_mem_adv", mem_memread, 1'b1);
    checkOutput("lu_release", {pc_write, ifid_write}, 2'b11);
    tick();
    checkOutput("lu_add_ex", ex_vec, EX_RTYPE);

    // Load to $0 never stalls
    applyStimulus(1'b1, 6'b100011, 5'd0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 1'b0);
    checkOutput("lu_r0", {pc_write, ifid_write}, 2'b11);
    tick();

    // rt match: sw uses rt (stall), addi does not (no stall)
    applyStimulus(1'b1, 6'b100011, 5'd0, 5'd7, 1'b0);
    tick();
    applyStimulus(1'b1, 6'b101011, 5'd0, 5'd7, 1'b0);
    checkOutput("lu_sw_rt", {pc_write, ifid_write}, 2'b00);
    applyStimulus(1'b1, 6'b001000, 5'd0, 5'd7, 1'b0);
    checkOutput("lu_addi_rt", {pc_write, ifid_write}, 2'b11);
    tick();

    // Taken bne: flush IF/ID and bubble ID/EX
    applyStimulus(1'b1, 6'b000101, 5'd1, 5'd2, 1'b0);
    tick();
    checkOutput("bne_ex", {ex_branch, ex_bne}, 2'b11);
    applyStimulus(1'b1, 6'b000000, 5'd3, 5'd4, 1'b1);
    checkOutput("bne_taken", {pc_write, ifid_write, ifid_flush}, 3'b111);
    tick();
    applyStimulus(1'b1, 6'b000000, 5'd3, 5'd4, 1'b0);
    checkOutput("bne_bubble", ex_vec, 8'h00);

    // Not taken bne: no flush, next instruction proceeds
    applyStimulus(1'b1, 6'b000101, 5'd1, 5'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 6'b000000, 5'd3, 5'd4, 1'b0);
    checkOutput("bne_nt_flush", ifid_flush, 1'b0);
    tick();
    checkOutput("bne_nt_ex", ex_vec, EX_RTYPE);

    // Hazard with jr in ID: stall first, flush on the re-decode
    applyStimulus(1'b1, 6'b100011, 5'd0, 5'd5, 1'b0);
    tick();
    applyStimulus(1'b1, 6'b010000, 5'd5, 5'd0, 1'b0);
    checkOutput("jr_stall", {pc_write, ifid_write, ifid_flush}, 3'b000);
    tick();
    checkOutput("jr_flush", {pc_write, ifid_write, ifid_flush}, 3'b111);
    checkOutput("jr_bubble", ex_vec, 8'h00);
    tick();

    // Async reset pulse between edges clears all in-flight controls
    applyStimulus(1'b1, 6'b100011, 5'd0, 5'd9, 1'b0);
    tick();
    tick();
    checkOutput("pre_pulse", {ex_memread, mem_memread}, 2'b11);
    rst_n = 1'b0;
    #1;
    checkOutput("pulse_ex", {ex_vec, ex_rt}, 13'h0);
    checkOutput("pulse_mem_wb", {mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg}, 4'b0000);
    checkOutput("pulse_pc", pc_write, 1'b1);
    #1;
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
